multicycle_sequencer: RTL and testbench

- Multi-cycle FSM that steps the single shared datapath through fetch, decode, execute, memory and writeback phases, one instruction at a time.
- Owns the program counter and the instruction register, and issues the per-phase enable strobes to the datapath.
- Uses the 3-bit opcode set: 000 add, 001 beq, 010 sb, 011 lbu, 100 xor, 101 or, 110 and, 111 srl.
- Top level starts a program with `start` and waits for `done`.

---
 rtl/multicycle_sequencer.sv | 147 ++++++++++++++
 tb/tb_multicycle_sequencer.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_sequencer.sv
// Multi-cycle sequencer: steps one shared datapath through fetch/decode/exec/mem/writeback,
// owning pc and ir. Strobes are Moore decodes of state and ir; memory waits are bounded by MAX_WAIT.
module multicycle_sequencer #(
   parameter int              PC_W       = 10,
   parameter int              IW         = 9,
   parameter logic [IW-1:0]   HALT_INSTR = 9'h1FF,
   parameter int              MAX_WAIT   = 15,
   parameter int              CNT_W      = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [IW-1:0]    instr,
   input  logic             branch_taken,
   input  logic [PC_W-1:0]  branch_target,
   input  logic             mem_ready,
   output logic [PC_W-1:0]  pc,
   output logic [IW-1:0]    ir,
   output logic             alu_en,
   output logic             mem_req,
   output logic             mem_we,
   output logic             reg_we,
   output logic             done,
   output logic             err,
   output logic [2:0]       state,
   output logic [CNT_W-1:0] cycle_count
);
   localparam int                WAIT_W    = $clog2(MAX_WAIT + 1);
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);
   localparam logic [2:0]        OP_BEQ    = 3'b001;
   localparam logic [2:0]        OP_SB     = 3'b010;
   localparam logic [2:0]        OP_LBU    = 3'b011;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_MEM    = 3'd4,
      S_WB     = 3'd5,
      S_HALT   = 3'd6
   } state_t;

   state_t            state_q;
   logic [PC_W-1:0]   pc_q, pc_d;
   logic [IW-1:0]     ir_q;
   logic              done_q, err_q;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [WAIT_W-1:0] wait_q;
   logic [2:0]        op;
   logic              cnt_active;

   assign op         = ir_q[IW-1 -: 3];
   assign pc_d       = pc_q + 1'b1;
   assign cnt_d      = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
   assign cnt_active = (state_q >= S_FETCH) && (state_q <= S_WB);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         pc_q    <= '0;
         ir_q    <= '0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         cnt_q   <= '0;
         wait_q  <= '0;
      end else begin
         if (cnt_active) cnt_q <= cnt_d;
         case (state_q)
            S_IDLE: begin
               pc_q   <= '0;
               cnt_q  <= '0;
               done_q <= 1'b0;
               err_q  <= 1'b0;
               if (start) state_q <= S_FETCH;
            end
            S_FETCH: begin
               ir_q    <= instr;
               state_q <= S_DECODE;
            end
            S_DECODE: begin
               if (ir_q == HALT_INSTR) begin
                  done_q  <= 1'b1;
                  state_q <= S_HALT;
               end else begin
                  state_q <= S_EXEC;
               end
            end
            S_EXEC: begin
               case (op)
                  OP_BEQ: begin
                     pc_q    <= branch_taken ? branch_target : pc_d;
                     state_q <= S_FETCH;
                  end
                  OP_SB, OP_LBU: begin
                     wait_q  <= '0;
                     state_q <= S_MEM;
                  end
                  default: state_q <= S_WB;
               endcase
            end
            S_MEM: begin
               // a late mem_ready on the final allowed cycle still completes the access
               if (mem_ready) begin
                  if (op == OP_SB) begin
                     pc_q    <= pc_d;
                     state_q <= S_FETCH;
                  end else begin
                     state_q <= S_WB;
                  end
               end else if (wait_q == WAIT_LAST) begin
                  err_q   <= 1'b1;
                  done_q  <= 1'b1;
                  state_q <= S_HALT;
               end else begin
                  wait_q <= wait_q + 1'b1;
               end
            end
            S_WB: begin
               pc_q    <= pc_d;
               state_q <= S_FETCH;
            end
            S_HALT: begin
               if (start) begin
                  pc_q    <= '0;
                  cnt_q   <= '0;
                  done_q  <= 1'b0;
                  err_q   <= 1'b0;
                  state_q <= S_FETCH;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign alu_en      = (state_q == S_EXEC);
   assign mem_req     = (state_q == S_MEM);
   assign mem_we      = (state_q == S_MEM) && (op == OP_SB);
   assign reg_we      = (state_q == S_WB);
   assign pc          = pc_q;
   assign ir          = ir_q;
   assign done        = done_q;
   assign err         = err_q;
   assign state       = state_q;
   assign cycle_count = cnt_q;
endmodule

// File: tb/tb_multicycle_sequencer.sv
// Scoreboard bench: per-cycle expected trace records are queued by the stimulus and popped by a monitor.
module tb_multicycle_sequencer;
   localparam logic [8:0] HALT = 9'h1FF;
   localparam logic [8:0] ADD  = 9'h000;
   localparam logic [8:0] BEQ  = 9'h040;
   localparam logic [8:0] SB   = 9'h080;
   localparam logic [8:0] LBU  = 9'h0C0;
   localparam logic [8:0] XOR  = 9'h100;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset, start, branch_taken, mem_ready;
   logic [8:0]  instr, ir;
   logic [9:0]  branch_target, pc;
   logic        alu_en, mem_req, mem_we, reg_we, done, err;
   logic [2:0]  state;
   logic [15:0] cycle_count;

   logic        reset2, start2;
   logic [8:0]  instr2, ir2;
   logic [9:0]  pc2;
   logic        alu_en2, mem_req2, mem_we2, reg_we2, done2, err2;
   logic [2:0]  state2;
   logic [3:0]  cycle_count2;

   logic [8:0]  rom    [0:1023];
   logic        bt     [0:1023];
   logic [9:0]  btg    [0:1023];
   int          rdy_at [0:1023];
   int          memcyc = 0;

   assign instr         = rom[pc];
   assign branch_taken  = bt[pc];
   assign branch_target = btg[pc];
   assign mem_ready     = (state == 3'd4) && (rdy_at[pc] != 0) && (memcyc + 1 == rdy_at[pc]);
   always @(posedge clk) memcyc <= (state == 3'd4) ? memcyc + 1 : 0;

   assign instr2 = (pc2 == 10'd5) ? HALT : ADD;

   multicycle_sequencer dut (
      .clk(clk), .reset(reset), .start(start), .instr(instr),
      .branch_taken(branch_taken), .branch_target(branch_target), .mem_ready(mem_ready),
      .pc(pc), .ir(ir), .alu_en(alu_en), .mem_req(mem_req), .mem_we(mem_we), .reg_we(reg_we),
      .done(done), .err(err), .state(state), .cycle_count(cycle_count)
   );

   multicycle_sequencer #(.CNT_W(4)) dut2 (
      .clk(clk), .reset(reset2), .start(start2), .instr(instr2),
      .branch_taken(1'b0), .branch_target(10'd0), .mem_ready(1'b0),
      .pc(pc2), .ir(ir2), .alu_en(alu_en2), .mem_req(mem_req2), .mem_we(mem_we2), .reg_we(reg_we2),
      .done(done2), .err(err2), .state(state2), .cycle_count(cycle_count2)
   );

   typedef struct packed {
      logic [2:0]  st;
      logic [9:0]  pc;
      logic [3:0]  strb;   // {alu_en, mem_req, mem_we, reg_we}
      logic        dn;
      logic        er;
      logic        chk;
      logic [15:0] cnt;
   } exp_t;

   exp_t q[$];
   exp_t q2[$];
   int   n_chk  = 0;
   int   n_pass = 0;
   logic mon_en = 1'b0;
   logic mon2_en = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
      n_chk++;
      if (act === want) n_pass++;
      else $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, want);
   endtask

   task automatic a(input logic [2:0] s_i, input logic [9:0] p_i, input logic [3:0] b_i);
      q.push_back('{st: s_i, pc: p_i, strb: b_i, dn: 1'b0, er: 1'b0, chk: 1'b0, cnt: 16'd0});
   endtask

   task automatic h(input logic [9:0] p_i, input logic e_i, input logic [15:0] c_i);
      q.push_back('{st: 3'd6, pc: p_i, strb: 4'd0, dn: 1'b1, er: e_i, chk: 1'b1, cnt: c_i});
   endtask

   task automatic i_alu(input logic [9:0] p_i);
      a(1, p_i, 0); a(2, p_i, 0); a(3, p_i, 4'b1000); a(5, p_i, 4'b0001);
   endtask

   task automatic i_beq(input logic [9:0] p_i);
      a(1, p_i, 0); a(2, p_i, 0); a(3, p_i, 4'b1000);
   endtask

   task automatic i_mem(input logic [9:0] p_i, input logic store, input int n);
      a(1, p_i, 0); a(2, p_i, 0); a(3, p_i, 4'b1000);
      repeat (n) a(4, p_i, store ? 4'b0110 : 4'b0100);
      if (!store) a(5, p_i, 4'b0001);
   endtask

   task automatic pulse_start();
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
   endtask

   task automatic wait_st(input logic [2:0] s_i);
      int k = 0;
      while (state !== s_i && k < 300) begin
         @(negedge clk);
         k++;
      end
      if (state !== s_i) begin
         n_chk++;
         $display("FAIL wait_state: got state %0d want %0d after %0d cycles", state, s_i, k);
      end
   endtask

   // One record per active cycle, plus one on every state change (entry to HALT or IDLE).
   always @(negedge clk) begin : mon
      exp_t e;
      logic [2:0] prev_st;
      int idx;
      if (mon_en && ((state >= 3'd1 && state <= 3'd5) || state != prev_st)) begin
         if (q.size() == 0) begin
            n_chk++;
            $display("FAIL trace[%0d]: got unexpected state %0d pc %0h want no output", idx, state, pc);
         end else begin
            e = q.pop_front();
            chk($sformatf("trace[%0d] {st,pc,strb,done,err}", idx),
                {15'd0, state, pc, alu_en, mem_req, mem_we, reg_we, done, err},
                {15'd0, e.st, e.pc, e.strb, e.dn, e.er});
            if (e.chk) chk($sformatf("trace[%0d] cycle_count", idx), {16'd0, cycle_count}, {16'd0, e.cnt});
         end
         idx++;
      end
      prev_st = state;
   end

   always @(negedge clk) begin : mon2
      exp_t e;
      logic [2:0] prev2;
      if (mon2_en && state2 == 3'd6 && prev2 != 3'd6) begin
         if (q2.size() == 0) begin
            n_chk++;
            $display("FAIL sat_halt: got unexpected halt want no output");
         end else begin
            e = q2.pop_front();
            chk("sat pc", {22'd0, pc2}, {22'd0, e.pc});
            chk("sat done", {31'd0, done2}, {31'd0, e.dn});
            chk("sat cycle_count", {28'd0, cycle_count2}, {16'd0, e.cnt});
         end
      end
      prev2 = state2;
   end

   initial begin
      reset = 1'b1; start = 1'b0; reset2 = 1'b1; start2 = 1'b0;
      for (int i = 0; i < 1024; i++) begin
         rom[i] = HALT; bt[i] = 1'b1; btg[i] = 10'h155; rdy_at[i] = 0;
      end
      repeat (3) @(negedge clk);
      reset = 1'b0; reset2 = 1'b0;
      chk("reset state", {29'd0, state}, 32'd0);
      chk("reset pc", {22'd0, pc}, 32'd0);
      chk("reset ir", {23'd0, ir}, 32'd0);
      chk("reset strobes", {28'd0, alu_en, mem_req, mem_we, reg_we}, 32'd0);
      chk("reset done", {31'd0, done}, 32'd0);
      chk("reset err", {31'd0, err}, 32'd0);
      chk("reset cycle_count", {16'd0, cycle_count}, 32'd0);
      mon_en = 1'b1;

      // add, halt; a start pulse during EXEC must be ignored
      rom[0] = ADD; rom[1] = HALT;
      i_alu(0); a(1, 1, 0); a(2, 1, 0); h(1, 0, 6);
      pulse_start();
      wait_st(3);
      start = 1'b1;
      @(negedge clk) start = 1'b0;
      wait_st(6);

      // beq to 3FF, xor wraps pc to 0, xor, then a store that never completes
      rom[0] = BEQ; bt[0] = 1'b1; btg[0] = 10'h3FF;
      rom[10'h3FF] = XOR; rom[1] = SB; rdy_at[1] = 0;
      i_beq(0); i_alu(10'h3FF); i_alu(0); i_mem(1, 1'b1, 15); h(1, 1, 29);
      pulse_start();
      wait_st(2);
      rom[0] = XOR;
      wait_st(6);

      // restart from HALT: taken/not-taken branches, lbu (ready on 3rd MEM), sb (ready on 1st)
      rom[0]  = BEQ; bt[0]  = 1'b1; btg[0]  = 10'd4;
      rom[4]  = BEQ; bt[4]  = 1'b1; btg[4]  = 10'd20;
      rom[20] = BEQ; bt[20] = 1'b0; btg[20] = 10'h2AA;
      rom[21] = LBU; rdy_at[21] = 3;
      rom[22] = SB;  rdy_at[22] = 1;
      rom[23] = HALT;
      i_beq(0); i_beq(4); i_beq(20); i_mem(21, 1'b0, 3); i_mem(22, 1'b1, 1);
      a(1, 23, 0); a(2, 23, 0); h(23, 0, 22);
      pulse_start();
      wait_st(6);

      // reset while a load is waiting in MEM
      rom[0] = ADD; rom[1] = LBU; rdy_at[1] = 0;
      i_alu(0); a(1, 1, 0); a(2, 1, 0); a(3, 1, 4'b1000); a(4, 1, 4'b0100);
      q.push_back('{st: 3'd0, pc: 10'd0, strb: 4'd0, dn: 1'b0, er: 1'b0, chk: 1'b1, cnt: 16'd0});
      pulse_start();
      wait_st(4);
      reset = 1'b1;
      @(negedge clk) reset = 1'b0;
      repeat (3) @(negedge clk);

      // 4-bit cycle counter: 5 adds + halt = 22 cycles, must saturate at 15
      q2.push_back('{st: 3'd6, pc: 10'd5, strb: 4'd0, dn: 1'b1, er: 1'b0, chk: 1'b1, cnt: 16'd15});
      mon2_en = 1'b1;
      @(negedge clk) start2 = 1'b1;
      @(negedge clk) start2 = 1'b0;
      for (int k = 0; k < 100 && state2 != 3'd6; k++) @(negedge clk);
      repeat (2) @(negedge clk);

      chk("trace queue drained", q.size(), 32'd0);
      chk("sat queue drained", q2.size(), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
